mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter CNT_W, default 16, width of the memory-stall cycle counter.
REQ-002 clk  input  1  single clock; every register updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 valid_E  input  1  the Execute-stage instruction is real and not a bubble.
REQ-005 pc_E  input  32  PC of the Execute-stage instruction.
REQ-006 alu_E  input  32  ALU result, which is also the memory address.
REQ-007 sdata_E  input  32  store data (forwarded rs2).
REQ-008 rd_E  input  5  destination register.
REQ-009 rf_en_E  input  1  instruction writes the register file.
REQ-010 mem_rd_E, mem_wr_E  input  1 each  word load or word store.
REQ-011 wb_sel_E  input  2  writeback source: 0 ALU, 1 load data, 2 PC+4, 3 reserved (treated as 0).
REQ-012 dmem_req  output  1  data-memory request.
REQ-013 dmem_we  output  1  request is a write.
REQ-014 dmem_addr  output  32  request address.
REQ-015 dmem_wdata  output  32  write data.
REQ-016 dmem_ack  input  1  request completes this cycle.
REQ-017 dmem_rdata  input  32  read data, valid while dmem_ack=1.
REQ-018 rd_M  output  5  destination register of the M instruction, sent to forwarding/hazard logic.
REQ-019 rf_en_M  output  1  M instruction will write rd_M.
REQ-020 stall_M  output  1  freezes all upstream stages (PC, decode register, Execute outputs).
REQ-021 wb_en  output  1  register-file write enable.
REQ-022 wb_rd  output  5  register-file write address.
REQ-023 wb_data  output  32  register-file write data; also the forwarding value.
REQ-024 misalign  output  1  one-cycle pulse on a misaligned access.
REQ-025 stall_cnt  output  CNT_W  number of memory-stall cycles, saturating.

Function
REQ-026 The M register holds: valid_M, pc_M, alu_M, sdata_M, rd_M, rf_en, mem_rd, mem_wr, wb_sel.
- When stall_M=0, it loads all E inputs on each edge.
- When stall_M=1, it holds its contents.
REQ-027 mem_op = valid_M & (mem_rd|mem_wr) & (alu_M[1:0]==0).
REQ-028 misalign = valid_M & (mem_rd|mem_wr) & (alu_M[1:0]!=0), combinational.
- No request is issued.
- No register-file write occurs.
- The instruction retires in one cycle.
REQ-029 FSM states: IDLE and WAIT.
- IDLE to WAIT when mem_op=1 and dmem_ack=0.
- WAIT to IDLE when dmem_ack=1.
- Every other case holds the current state.
REQ-030 dmem_req = mem_op in both states.
- It is asserted in the first M cycle of the instruction, so zero-wait memory completes in that same cycle.
- It stays high without a gap until the acknowledge.
REQ-031 While dmem_req=1:
- dmem_we = mem_wr.
- dmem_addr = alu_M.
- dmem_wdata = sdata_M.
- All three stay stable until dmem_ack.
REQ-032 dmem_ack is ignored when dmem_req=0.
REQ-033 stall_M = mem_op & ~dmem_ack, combinational.
- The acknowledge cycle releases the stall within that same cycle.
REQ-034 rd_M = rd register.
REQ-035 rf_en_M = valid_M & rf_en & ~misalign.
REQ-036 wb_en = rf_en_M & ~stall_M & (rd_M!=0).
REQ-037 wb_rd = rd_M.
REQ-038 wb_data by wb_sel:
- 0: alu_M.
- 1: dmem_rdata.
- 2: pc_M+4, modulo 2^32.
- 3: alu_M.
REQ-039 A store with rf_en=1 still writes ALU/PC data as wb_sel selects.
- A load whose rf_en=0 is acknowledged with no writeback.
REQ-040 stall_cnt increments by 1 each cycle that stall_M=1.
- It saturates at 2^CNT_W-1 and never wraps.
REQ-041 While stall_M=1, a valid_E instruction is held by the upstream stages and is not lost.
- It is captured on the first edge where stall_M=0.
REQ-042 An instruction that is a bubble (valid_E=0) produces no request and no writeback.

Reset
REQ-043 While rst=0:
- The FSM is forced to IDLE.
- valid_M=0 and all other M register fields are 0.
- stall_cnt=0.
REQ-044 Because valid_M=0 under reset, these outputs are 0 immediately, with no clock edge needed: dmem_req, stall_M, wb_en, rf_en_M, misalign.
REQ-045 rst asserted during WAIT abandons the request. After release, the block restarts in IDLE with an empty M stage.

Verification
REQ-046 Zero-wait load: lw, alu=0x100, rd=5, wb_sel=1, dmem_ack=1 in the same cycle, rdata=0xDEADBEEF.
- wb_en=1, wb_rd=5, wb_data=0xDEADBEEF.
- stall_M stays 0.
- stall_cnt=0.
REQ-047 Three-wait-state store: alu=0x200, sdata=0x1234, ack on the 4th M cycle.
- dmem_req/we=1 for 4 cycles, with addr and data stable.
- stall_M=1 for exactly 3 cycles.
- stall_cnt=3.
- The next instruction is captured on the edge after the ack.
REQ-048 Misaligned load, alu=0x102.
- misalign=1 for 1 cycle.
- dmem_req=0, wb_en=0, stall_M=0.
REQ-049 ALU op with rd=0 and rf_en=1: wb_en=0 and rf_en_M=1.
- JAL-style op, pc=0xFFFFFFFC, wb_sel=2: wb_data=0x00000000.
REQ-050 Reset pulsed low while in WAIT: dmem_req and stall_M drop asynchronously.
- After release, a new zero-wait load completes normally.
REQ-051 Back-to-back loads, each acknowledged 1 cycle late: each load produces exactly one wb_en pulse, with the correct data for each.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: M register, data-memory handshake with wait states,
// misalignment detection, writeback selection and a saturating stall counter.
module mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_E,
  input  logic [31:0]      pc_E,
  input  logic [31:0]      alu_E,
  input  logic [31:0]      sdata_E,
  input  logic [4:0]       rd_E,
  input  logic             rf_en_E,
  input  logic             mem_rd_E,
  input  logic             mem_wr_E,
  input  logic [1:0]       wb_sel_E,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic [4:0]       rd_M,
  output logic             rf_en_M,
  output logic             stall_M,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]       state_r;
  logic [0:0]       next_state_s;
  logic             valid_r;
  logic [31:0]      pc_r;
  logic [31:0]      alu_r;
  logic [31:0]      sdata_r;
  logic [4:0]       rd_r;
  logic             rf_en_r;
  logic             mem_rd_r;
  logic             mem_wr_r;
  logic [1:0]       wb_sel_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             mem_acc_s;
  logic             mem_op_s;
  logic             misalign_s;
  logic             stall_s;
  logic             rf_en_m_s;
  logic [31:0]      wb_data_s;

  // Request depends only on the M contents, so a zero-wait memory completes
  // in the first M cycle and the request never gaps before the acknowledge.
  assign mem_acc_s  = valid_r & (mem_rd_r | mem_wr_r);
  assign mem_op_s   = mem_acc_s & (alu_r[1:0] == 2'b00);
  assign misalign_s = mem_acc_s & (alu_r[1:0] != 2'b00);
  assign stall_s    = mem_op_s & ~dmem_ack;
  assign rf_en_m_s  = valid_r & rf_en_r & ~misalign_s;

  assign dmem_req   = mem_op_s;
  assign dmem_we    = mem_wr_r;
  assign dmem_addr  = alu_r;
  assign dmem_wdata = sdata_r;
  assign rd_M       = rd_r;
  assign rf_en_M    = rf_en_m_s;
  assign stall_M    = stall_s;
  assign wb_en      = rf_en_m_s & ~stall_s & (rd_r != 5'd0);
  assign wb_rd      = rd_r;
  assign wb_data    = wb_data_s;
  assign misalign   = misalign_s;
  assign stall_cnt  = stall_cnt_r;

  // Next-state logic for the request-tracking FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !dmem_ack) next_state_s = WAIT;
        else                       next_state_s = IDLE;
      end
      WAIT: begin
        if (dmem_ack) next_state_s = IDLE;
        else          next_state_s = WAIT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Writeback source select; the reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data_s = alu_r;
    case (wb_sel_r)
      2'd0:    wb_data_s = alu_r;
      2'd1:    wb_data_s = dmem_rdata;
      2'd2:    wb_data_s = pc_r + 32'd4;
      2'd3:    wb_data_s = alu_r;
      default: wb_data_s = alu_r;
    endcase
  end

  // M pipeline register: loads from Execute unless the stage is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      pc_r     <= 32'd0;
      alu_r    <= 32'd0;
      sdata_r  <= 32'd0;
      rd_r     <= 5'd0;
      rf_en_r  <= 1'b0;
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      wb_sel_r <= 2'd0;
    end else if (!stall_s) begin
      valid_r  <= valid_E;
      pc_r     <= pc_E;
      alu_r    <= alu_E;
      sdata_r  <= sdata_E;
      rd_r     <= rd_E;
      rf_en_r  <= rf_en_E;
      mem_rd_r <= mem_rd_E;
      mem_wr_r <= mem_wr_E;
      wb_sel_r <= wb_sel_E;
    end
  end

  // FSM state register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_state_s;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
